// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL/STATUS bit positions and default ID for avalon_timer_regs
package timer_pkg;
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_LOAD     = 3'd2;
  localparam logic [2:0] ADDR_COUNT    = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_CAPTURE  = 3'd5;
  localparam logic [2:0] ADDR_ID       = 3'd6;
  localparam logic [2:0] ADDR_SCRATCH  = 3'd7;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_TO       = 0;
  localparam int ST_RUN      = 1;
  localparam logic [31:0] ID_DEFAULT = 32'h54494D31;
endpackage

// File: rtl/avalon_timer_regs_if.sv
// avalon_timer_regs_if: decoded register-access stream between the Avalon bridge and a peripheral
interface avalon_timer_regs_if;
  logic        reg_read;
  logic        reg_write;
  logic [2:0]  reg_address;
  logic [31:0] reg_writedata;
  logic [31:0] reg_readdata;
  modport master (output reg_read, reg_write, reg_address, reg_writedata, input reg_readdata);
  modport slave (input reg_read, reg_write, reg_address, reg_writedata, output reg_readdata);
endinterface

// File: rtl/timer_core.sv
// timer_core: prescaler plus down-counter; timeout pulses on the tick that finds count at zero
module timer_core #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               reload,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               load_stb,
  input  logic [CNT_W-1:0]   load_val,
  input  logic [CNT_W-1:0]   load,
  output logic [CNT_W-1:0]   count,
  output logic               tick,
  output logic               timeout
);
  logic [PRESC_W-1:0] pcnt;
  assign tick    = en && pcnt == prescale;
  assign timeout = tick && count == '0;
  // a LOAD write overrides any decrement or reload on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      count <= '0;
    end else begin
      pcnt  <= (!en || tick || load_stb) ? '0 : pcnt + PRESC_W'(1);
      count <= load_stb   ? load_val :
               !tick      ? count :
               count != '0 ? count - CNT_W'(1) :
               reload     ? load : count;
    end
  end
endmodule

// File: rtl/avalon_timer_regs.sv
// avalon_timer_regs: register-mapped prescaled down-counter timer with sticky timeout and level irq.
// Define TIMER_CAPTURE_EN to add the COUNT snapshot register at address 5.
module avalon_timer_regs
  import timer_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter int          PRESC_W  = 16,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  avalon_timer_regs_if.slave  bus,
  output logic                irq
);
  logic               en, reload, irq_en, to;
  logic [PRESC_W-1:0] prescale;
  logic [CNT_W-1:0]   load, count;
  logic [31:0]        scratch, rdata;
  logic               unused_tick, timeout;
  logic               wr_ctrl, wr_presc, wr_load, wr_status, wr_scratch;
  assign wr_ctrl    = bus.reg_write && bus.reg_address == ADDR_CTRL;
  assign wr_presc   = bus.reg_write && bus.reg_address == ADDR_PRESCALE;
  assign wr_load    = bus.reg_write && bus.reg_address == ADDR_LOAD;
  assign wr_status  = bus.reg_write && bus.reg_address == ADDR_STATUS;
  assign wr_scratch = bus.reg_write && bus.reg_address == ADDR_SCRATCH;
  assign irq = to & irq_en;
  timer_core #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .reload   (reload),
    .prescale (prescale),
    .load_stb (wr_load),
    .load_val (bus.reg_writedata[CNT_W-1:0]),
    .load     (load),
    .count    (count),
    .tick     (unused_tick),
    .timeout  (timeout)
  );
`ifdef TIMER_CAPTURE_EN
  logic [CNT_W-1:0] capture;
  always_ff @(posedge clk) begin
    if (rst) capture <= '0;
    else if (bus.reg_write && bus.reg_address == ADDR_CAPTURE) capture <= count;
  end
`endif
  always_comb begin
    rdata = '0;
    case (bus.reg_address)
      ADDR_CTRL:     rdata = 32'({irq_en, reload, en});
      ADDR_PRESCALE: rdata = 32'(prescale);
      ADDR_LOAD:     rdata = 32'(load);
      ADDR_COUNT:    rdata = 32'(count);
      ADDR_STATUS:   rdata = 32'({en, to});
`ifdef TIMER_CAPTURE_EN
      ADDR_CAPTURE:  rdata = 32'(capture);
`endif
      ADDR_ID:       rdata = ID_VALUE;
      ADDR_SCRATCH:  rdata = scratch;
      default:       rdata = '0;
    endcase
  end
  // a CTRL write beats the one-shot EN clear; a hardware timeout beats the W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      en               <= 1'b0;
      reload           <= 1'b0;
      irq_en           <= 1'b0;
      to               <= 1'b0;
      prescale         <= '0;
      load             <= '0;
      scratch          <= '0;
      bus.reg_readdata <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= bus.reg_writedata[CTRL_EN];
        reload <= bus.reg_writedata[CTRL_RELOAD];
        irq_en <= bus.reg_writedata[CTRL_IRQ_EN];
      end else if (timeout && !reload) en <= 1'b0;
      if (wr_presc) prescale <= bus.reg_writedata[PRESC_W-1:0];
      if (wr_load) load <= bus.reg_writedata[CNT_W-1:0];
      if (wr_scratch) scratch <= bus.reg_writedata;
      to <= timeout || (to && !(wr_status && bus.reg_writedata[ST_TO]));
      if (bus.reg_read) bus.reg_readdata <= rdata;
    end
  end
endmodule

// File: tb/tb_avalon_timer_regs.sv
// tb_avalon_timer_regs: directed register-access bench; reads queue expected data, a monitor checks it
module tb_avalon_timer_regs;
  import timer_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic irq;
  logic rd_pend = 1'b0;
  int checks = 0;
  int failures = 0;
  typedef struct {string name; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  avalon_timer_regs_if bus ();
  avalon_timer_regs dut (.clk(clk), .rst(rst), .bus(bus.slave), .irq(irq));
  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  always @(posedge clk) rd_pend <= bus.reg_read;
  always @(negedge clk) begin
    exp_t e;
    if (rd_pend) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got %h expected none", bus.reg_readdata);
      end else begin
        e = sb.pop_front();
        check(e.name, bus.reg_readdata, e.exp);
      end
    end
  end
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.reg_write = 1'b1;
    bus.reg_address = a;
    bus.reg_writedata = d;
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    bus.reg_read = 1'b1;
    bus.reg_address = a;
    sb.push_back('{n, e});
    @(negedge clk);
    bus.reg_read = 1'b0;
  endtask
  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    bus.reg_write = 1'b1;
    bus.reg_writedata = d;
    rd(a, e, n);
    bus.reg_write = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    bus.reg_read = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_address = '0;
    bus.reg_writedata = '0;
    idle(3);
    check("rst_irq", irq, 0);
    check("rst_rdata", bus.reg_readdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rd(3'(i), i == 6 ? ID_DEFAULT : 32'h0, "reset_map");
    rd(ADDR_ID, ID_DEFAULT, "id");
    idle(2);
    check("rdata_hold", bus.reg_readdata, ID_DEFAULT);
    wr(ADDR_CTRL, 32'hFFFF_FFF8);
    rd(ADDR_CTRL, 0, "ctrl_rsvd");
    wr(ADDR_PRESCALE, 32'hFFFF_FFFF);
    rd(ADDR_PRESCALE, 32'h0000_FFFF, "presc_width");
    wr(ADDR_PRESCALE, 0);
    wr(ADDR_COUNT, 55);
    rd(ADDR_COUNT, 0, "count_ro");
    wr(ADDR_SCRATCH, 32'hA5A5_0001);
    rw(ADDR_SCRATCH, 32'h1234_5678, 32'hA5A5_0001, "rw_old");
    rd(ADDR_SCRATCH, 32'h1234_5678, "scratch");
    // one-shot, prescale 0, load 3
    wr(ADDR_LOAD, 3);
    wr(ADDR_CTRL, 32'h5);
    rd(ADDR_COUNT, 3, "os_c3");
    rd(ADDR_COUNT, 2, "os_c2");
    rd(ADDR_COUNT, 1, "os_c1");
    check("os_irq_pre", irq, 0);
    rd(ADDR_COUNT, 0, "os_c0");
    check("os_irq", irq, 1);
    rd(ADDR_STATUS, 1, "os_status");
    rd(ADDR_CTRL, 4, "os_ctrl");
    rd(ADDR_COUNT, 0, "os_hold");
    wr(ADDR_STATUS, 1);
    check("w1c_irq", irq, 0);
    // auto-reload, prescale 4, load 1: timeout every 10 cycles
    wr(ADDR_CTRL, 0);
    wr(ADDR_PRESCALE, 4);
    wr(ADDR_LOAD, 1);
    wr(ADDR_CTRL, 32'h3);
    idle(8);
    rd(ADDR_STATUS, 2, "ar_pre");
    rd(ADDR_STATUS, 2, "ar_edge");
    rd(ADDR_STATUS, 3, "ar_set");
    check("ar_irq_masked", irq, 0);
    wr(ADDR_STATUS, 1);
    rd(ADDR_STATUS, 2, "ar_clr");
    idle(5);
    rd(ADDR_STATUS, 2, "ar2_pre");
    rd(ADDR_STATUS, 2, "ar2_edge");
    rd(ADDR_STATUS, 3, "ar2_set");
    // W1C on the timeout edge
    wr(ADDR_CTRL, 32'h7);
    check("irq_en_on", irq, 1);
    wr(ADDR_STATUS, 1);
    check("irq_clr", irq, 0);
    idle(6);
    wr(ADDR_STATUS, 1);
    check("w1c_collide_irq", irq, 1);
    rd(ADDR_STATUS, 3, "w1c_collide");
    // LOAD write on a tick edge with COUNT=2
    wr(ADDR_CTRL, 0);
    wr(ADDR_STATUS, 1);
    wr(ADDR_PRESCALE, 0);
    wr(ADDR_LOAD, 4);
    wr(ADDR_CTRL, 32'h3);
    rd(ADDR_COUNT, 4, "lt_c4");
    rd(ADDR_COUNT, 3, "lt_c3");
    wr(ADDR_LOAD, 7);
    rd(ADDR_COUNT, 7, "lt_load_wins");
    rd(ADDR_COUNT, 6, "lt_c6");
    wr(ADDR_CTRL, 32'h7);
    idle(5);
    check("pre_rst_irq", irq, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_irq", irq, 0);
    check("mid_rst_rdata", bus.reg_readdata, 0);
    rd(ADDR_COUNT, 0, "mid_rst_count");
    rd(ADDR_STATUS, 0, "mid_rst_status");
    rd(ADDR_CTRL, 0, "mid_rst_ctrl");
    rd(ADDR_LOAD, 0, "mid_rst_load");
`ifdef TIMER_CAPTURE_EN
    wr(ADDR_LOAD, 100);
    wr(ADDR_CTRL, 1);
    idle(10);
    wr(ADDR_CAPTURE, 0);
    rd(ADDR_CAPTURE, 90, "capture");
    rd(ADDR_COUNT, 88, "capture_count_runs");
    idle(3);
    rd(ADDR_CAPTURE, 90, "capture_hold");
`else
    wr(ADDR_CAPTURE, 32'hDEAD_BEEF);
    rd(ADDR_CAPTURE, 0, "no_capture");
`endif
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
